// File: rtl/left_shift_serializer_pkg.sv
// ============================================================================
// Module  : left_shift_serializer_pkg
// Brief   : State encodings and counter width helper shared by the serializer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package left_shift_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/left_shift_serializer_counter.sv
// ============================================================================
// Module  : shift_bit_counter
// Brief   : Bit counter with clear, gated increment and last-bit flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_bit_counter
   import left_shift_serializer_pkg::*;
#(
   parameter int MAX = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_last
);

   localparam int                   c_cnt_w = cnt_w(MAX);
   localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(MAX - 1);
   localparam logic [c_cnt_w-1:0]   c_one   = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + c_one;
   end

   assign o_last = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/left_shift_serializer.sv
// ============================================================================
// Module  : left_shift_serializer
// Brief   : MSB-first parallel-in/serial-out transmitter with valid/ready load.
//           Optional trailing even-parity bit: LEFT_SHIFT_SERIALIZER_PARITY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module left_shift_serializer
   import left_shift_serializer_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load_valid,
   input  logic [DEPTH-1:0] load_data,
   output logic             load_ready,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   logic [DEPTH-1:0] r_shreg;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_done;

   logic             w_cnt_last;
   logic             w_cnt_inc;
   logic             w_last_edge;
   logic             w_accept;

`ifdef LEFT_SHIFT_SERIALIZER_PARITY_EN
   logic             r_par;
   assign w_last_edge = (r_state == ST_PARITY) & enable;
`else
   assign w_last_edge = (r_state == ST_SHIFT) & enable & w_cnt_last;
`endif

   // Ready on the last-bit edge lets the next word follow with no idle bit.
   assign load_ready = (r_state == ST_IDLE) | w_last_edge;
   assign w_accept   = load_valid & load_ready;
   assign w_cnt_inc  = (r_state == ST_SHIFT) & enable & ~w_cnt_last;

   shift_bit_counter #(
      .MAX     (DEPTH)
   ) u_cnt (
      .clk     (clk),
      .rst     (reset),
      .i_clear (w_accept),
      .i_inc   (w_cnt_inc),
      .o_last  (w_cnt_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef LEFT_SHIFT_SERIALIZER_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_done <= w_last_edge;
         if (w_accept) begin
            r_state     <= ST_SHIFT;
            r_shreg     <= load_data;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
`ifdef LEFT_SHIFT_SERIALIZER_PARITY_EN
            r_par       <= ^load_data;
`endif
         end else if (enable) begin
            case (r_state)
               ST_SHIFT: begin
                  if (w_cnt_last) begin
`ifdef LEFT_SHIFT_SERIALIZER_PARITY_EN
                     // Parity rides in the MSB so out needs no extra mux.
                     r_shreg <= {r_par, {(DEPTH-1){1'b0}}};
                     r_state <= ST_PARITY;
`else
                     r_shreg     <= '0;
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
`endif
                  end else begin
                     r_shreg <= r_shreg << 1;
                  end
               end
`ifdef LEFT_SHIFT_SERIALIZER_PARITY_EN
               ST_PARITY: begin
                  r_shreg     <= '0;
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign out       = r_shreg[DEPTH-1];
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

`default_nettype wire
